// File: rtl/ahblite_uart.sv
// AHB-Lite UART: TX FIFO + serial TX, 1-byte RX holding reg, level IRQ.
// Ports: AHB-Lite slave (HCLK/HRESETn/H*), RXD, TXD, interrupt_UART.
// Optional: define UART_LOOPBACK_EN to enable CTRL[2] TX->RX loopback.
module ahblite_uart #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        RXD,
  output logic        TXD,
  output logic        interrupt_UART
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
`ifdef UART_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_e;

  logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  st_e         tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic        tx_ovr_q, tx_ovr_d, ferr_q, ferr_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  logic        valid, tx_empty, tx_full, pop, wr_data, push_ok;
  logic        lb, txd_int, rx_in;
  logic [16:0] half;
  logic        unused;

  assign unused = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0],
                    HTRANS[0], HWDATA[31:16], half[16]};

  assign valid    = HSEL & HTRANS[1] & HREADY;
  assign tx_empty = (wptr_q == rptr_q);
  assign tx_full  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop      = (tx_st_q == S_IDLE) & ~tx_empty;
  assign wr_data  = wr_en_q & (addr_q == 2'd0);
  // a push into a full FIFO still fits if the FSM pops this cycle
  assign push_ok  = wr_data & (~tx_full | pop);
  assign half     = ({1'b0, baud_q} + 17'd1) >> 1;

  assign lb      = ctrl_q[2];
  assign txd_int = (tx_st_q == S_START) ? 1'b0 :
                   (tx_st_q == S_DATA)  ? tx_sh_q[tx_bit_q] : 1'b1;
  assign TXD     = txd_int | lb;
  assign rx_in   = lb ? txd_int : RXD;

  assign HREADYOUT      = 1'b1;
  assign HRESP          = 1'b0;
  assign interrupt_UART = irq_q;

  always_comb begin
    HRDATA = '0;
    if (rd_en_q) begin
      unique case (addr_q)
        2'd0: HRDATA = {24'b0, rx_byte_q};
        2'd1: HRDATA = {26'b0, ferr_q, tx_ovr_q, rx_ovr_q,
                        rx_valid_q, tx_empty, tx_full};
        2'd2: HRDATA = {16'b0, baud_q};
        default: HRDATA = {29'b0, ctrl_q};
      endcase
    end
  end

  always_comb begin
    wr_en_d    = valid & HWRITE;
    rd_en_d    = valid & ~HWRITE;
    addr_d     = valid ? HADDR[3:2] : addr_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    tx_ovr_d   = tx_ovr_q;
    ferr_d     = ferr_q;
    baud_d     = baud_q;
    ctrl_d     = ctrl_q;

    if (wr_en_q) begin
      unique case (addr_q)
        2'd1: begin
          if (HWDATA[3]) rx_ovr_d = 1'b0;
          if (HWDATA[4]) tx_ovr_d = 1'b0;
          if (HWDATA[5]) ferr_d   = 1'b0;
        end
        2'd2: baud_d = HWDATA[15:0];
        2'd3: ctrl_d = HWDATA[2:0] & CTRL_MASK;
        default: ;
      endcase
    end
    if (rd_en_q && addr_q == 2'd0) rx_valid_d = 1'b0;

    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop) rptr_d = rptr_q + PTR_ONE;
    if (wr_data & tx_full & ~pop) tx_ovr_d = 1'b1;

    unique case (tx_st_q)
      S_IDLE: if (pop) begin
        tx_st_d  = S_START;
        tx_cnt_d = baud_q;
        tx_sh_d  = mem_q[rptr_q[AW-1:0]];
      end
      S_START: if (tx_cnt_q == '0) begin
        tx_st_d  = S_DATA;
        tx_cnt_d = baud_q;
        tx_bit_d = 3'd0;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      S_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = baud_q;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      default: if (tx_cnt_q == '0) tx_st_d = S_IDLE;
        else tx_cnt_d = tx_cnt_q - 16'd1;
    endcase

    unique case (rx_st_q)
      S_IDLE: if (rx_prev_q & ~rx_s2_q) begin
        rx_st_d  = S_START;
        rx_cnt_d = half[15:0];
      end
      S_START: if (rx_cnt_q == '0) begin
        // line back high at mid-start: glitch
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        rx_cnt_d = baud_q;
        rx_bit_d = 3'd0;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      S_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_cnt_d = baud_q;
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      default: if (rx_cnt_q == '0) begin
        rx_st_d = S_IDLE;
        if (rx_s2_q) begin
          rx_byte_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          if (rx_valid_q) rx_ovr_d = 1'b1;
        end else ferr_d = 1'b1;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
    endcase

    irq_d = (ctrl_q[0] & tx_empty & (tx_st_q == S_IDLE)) |
            (ctrl_q[1] & rx_valid_d);
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= 2'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_ovr_q   <= 1'b0;
      ferr_q     <= 1'b0;
      baud_q     <= BAUD_RESET;
      ctrl_q     <= '0;
      irq_q      <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovr_q   <= tx_ovr_d;
      ferr_q     <= ferr_d;
      baud_q     <= baud_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
      rx_s1_q    <= rx_in;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_ahblite_uart.sv
// Testbench for ahblite_uart: directed bus/serial stimulus,
// frame-level TXD model compared every cycle, literal register checks.
module tb_ahblite_uart;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [3:0]  HPROT = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic        RXD = 1'b1;
  logic        TXD, interrupt_UART;

  ahblite_uart #(.FIFO_DEPTH(4), .BAUD_RESET(16'd433)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .RXD(RXD), .TXD(TXD),
    .interrupt_UART(interrupt_UART)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Frame model: each accepted byte becomes a frame with a start cycle.
  int         fr_s[$];
  int         fr_b[$];
  logic [7:0] fr_d[$];
  int         m_baud = 433;
  bit         m_lb = 1'b0;
  bit         chk_en = 1'b0;

  function automatic logic model_txd(input int c);
    int p;
    int k;
    if (m_lb) return 1'b1;
    foreach (fr_s[i]) begin
      p = fr_b[i] + 1;
      if (c >= fr_s[i] && c < fr_s[i] + 10 * p) begin
        k = (c - fr_s[i]) / p;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fr_d[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  // d = data-phase cycle of the DATA write
  function automatic void model_push(input int d, input logic [7:0] b);
    int n;
    int s;
    int l;
    n = 0;
    foreach (fr_s[i]) if (fr_s[i] > d + 1) n++;
    if (n >= 4) return;
    s = d + 2;
    if (fr_s.size() > 0) begin
      l = fr_s.size() - 1;
      if (fr_s[l] + 10 * (fr_b[l] + 1) + 1 > s)
        s = fr_s[l] + 10 * (fr_b[l] + 1) + 1;
    end
    fr_s.push_back(s);
    fr_b.push_back(m_baud);
    fr_d.push_back(b);
  endfunction

  always @(negedge HCLK) begin
    if (chk_en && HRESETn)
      check("txd_model", 32'(TXD), 32'(model_txd(cyc)));
  end

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] v,
                        output int d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = v;
    d = cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    int d;
    bus_wr(a, v, d);
    if (a == 4'h0) model_push(d, v[7:0]);
    if (a == 4'h8) m_baud = int'(v[15:0]);
`ifdef UART_LOOPBACK_EN
    if (a == 4'hC) m_lb = v[2];
`endif
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp,
                        input string name);
    logic [31:0] v;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    v = HRDATA;
    @(posedge HCLK);
    #1;
    check(name, v, exp);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop,
                          input int bd);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      RXD = bits[i];
      repeat (bd) @(negedge HCLK);
    end
    @(negedge HCLK);
    RXD = 1'b1;
    repeat (3 * (bd + 1)) @(negedge HCLK);
  endtask

  initial begin
    logic [7:0] bts [5];
    bts = '{8'h01, 8'h80, 8'hF0, 8'h0F, 8'hC3};

    repeat (3) @(negedge HCLK);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_irq", 32'(interrupt_UART), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    HRESETn = 1'b1;
    chk_en = 1'b1;
    rd_chk(4'h4, 32'h2, "status_rst");
    rd_chk(4'h8, 32'h1B1, "baud_rst");
    rd_chk(4'hC, 32'h0, "ctrl_rst");
    check("hreadyout", 32'(HREADYOUT), 32'd1);
    check("hresp", 32'(HRESP), 32'd0);

    // single frame 0x55 at BAUDDIV=3
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h55);
    @(negedge HCLK);
    check("tx_pre_start", 32'(TXD), 32'd1);
    @(negedge HCLK);
    check("tx_start_bit", 32'(TXD), 32'd0);
    repeat (4) @(negedge HCLK);
    check("tx_bit0", 32'(TXD), 32'd1);
    repeat (40) @(negedge HCLK);
    rd_chk(4'h4, 32'h2, "status_tx_done");
    wr(4'hC, 32'h1);
    repeat (2) @(negedge HCLK);
    check("tx_irq", 32'(interrupt_UART), 32'd1);
    wr(4'hC, 32'h0);
    repeat (2) @(negedge HCLK);
    check("tx_irq_off", 32'(interrupt_UART), 32'd0);

    // five back-to-back bytes, sixth overflows
    for (int i = 0; i < 5; i++) wr(4'h0, {24'h0, bts[i]});
    wr(4'h0, 32'h99);
    rd_chk(4'h4, 32'h11, "status_full_ovr");
    wr(4'h4, 32'h10);
    rd_chk(4'h4, 32'h01, "status_ovr_clr");
    repeat (5 * 41 + 20) @(negedge HCLK);
    rd_chk(4'h4, 32'h2, "status_drained");

    // BAUDDIV=0: one cycle per bit
    wr(4'h8, 32'd0);
    rd_chk(4'h8, 32'h0, "baud_zero");
    wr(4'h0, 32'h81);
    repeat (20) @(negedge HCLK);
    rd_chk(4'h4, 32'h2, "status_baud0");

    // RX good frame
    wr(4'h8, 32'd7);
    rx_frame(8'hA3, 1'b1, 7);
    rd_chk(4'h4, 32'h6, "status_rx_valid");
    wr(4'hC, 32'h2);
    repeat (2) @(negedge HCLK);
    check("rx_irq", 32'(interrupt_UART), 32'd1);
    rd_chk(4'h0, 32'hA3, "rx_data_a3");
    @(negedge HCLK);
    check("rx_irq_drop", 32'(interrupt_UART), 32'd0);
    rd_chk(4'h4, 32'h2, "status_rx_read");

    // framing error
    rx_frame(8'h5A, 1'b0, 7);
    rd_chk(4'h4, 32'h22, "status_ferr");
    check("ferr_no_irq", 32'(interrupt_UART), 32'd0);
    wr(4'h4, 32'h20);
    rd_chk(4'h4, 32'h2, "status_ferr_clr");

    // overrun
    rx_frame(8'h11, 1'b1, 7);
    rx_frame(8'h22, 1'b1, 7);
    rd_chk(4'h4, 32'h0E, "status_rx_ovr");
    rd_chk(4'h0, 32'h22, "rx_data_second");
    rd_chk(4'h4, 32'h0A, "status_ovr_after_rd");
    wr(4'h4, 32'h08);
    rd_chk(4'h4, 32'h2, "status_ovr_clr2");
    wr(4'hC, 32'h0);

`ifdef UART_LOOPBACK_EN
    wr(4'h8, 32'd3);
    wr(4'hC, 32'h4);
    wr(4'h0, 32'h3C);
    repeat (60) @(negedge HCLK);
    rd_chk(4'h0, 32'h3C, "loopback_data");
    wr(4'hC, 32'h0);
`else
    wr(4'hC, 32'h7);
    rd_chk(4'hC, 32'h3, "ctrl_bit2_masked");
    wr(4'hC, 32'h0);
`endif

    // async reset in the middle of a frame of zeros
    wr(4'h0, 32'h00);
    repeat (6) @(negedge HCLK);
    check("mid_frame_low", 32'(TXD), 32'd0);
    #2;
    chk_en = 1'b0;
    HRESETn = 1'b0;
    #1;
    check("async_rst_txd", 32'(TXD), 32'd1);
    fr_s.delete();
    fr_b.delete();
    fr_d.delete();
    m_baud = 433;
    m_lb = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    chk_en = 1'b1;
    rd_chk(4'h4, 32'h2, "status_after_rst");
    rd_chk(4'h8, 32'h1B1, "baud_after_rst");
    repeat (5) @(negedge HCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
